// File: rtl/adc_par_read_ctrl.sv
// ---------------------------------------------------------------------------
// adc_par_read_ctrl
//
// Host-side controller for the parallel-bus sound-localization ADC. It pulses
// CONVST to all four channel pairs, waits for the BUSY pulse to complete, then
// reads NUM_CH 16-bit words with one CS_N low window and one RD_N low pulse
// per word. Each word goes out on a valid/ready sample stream.
//
// Optional feature (compile-time macro ADC_PAR_READ_OVERRUN_EN):
//   adds overrun_cnt, a saturating count of start pulses seen outside IDLE.
//
// Ports:
//   XCLK          in   system clock, rising edge
//   RST           in   asynchronous active-high reset
//   start         in   single-cycle frame request (ignored outside IDLE)
//   free_run      in   chain frames back to back after GAP
//   CONVST_A..D   out  conversion start, all four identical
//   CS_N          out  chip select, active low
//   RD_N          out  read strobe, active low
//   WR_N          out  write strobe, tied high
//   BUSY          in   ADC converting, asynchronous to XCLK
//   DB[15:0]      in   ADC data bus
//   sample_data   out  captured word
//   sample_ch     out  word index within the frame
//   sample_valid  out  stream valid
//   sample_ready  in   stream ready
//   frame_done    out  one-cycle pulse after the last word is accepted
//   timeout_err   out  sticky BUSY timeout flag, cleared only by RST
//   idle          out  high while the FSM is in IDLE
//   overrun_cnt   out  (macro only) dropped start pulse count, saturating
// ---------------------------------------------------------------------------
module adc_par_read_ctrl #(
    parameter int NUM_CH        = 8,
    parameter int CONVST_HI_CYC = 2,
    parameter int RD_LO_CYC     = 1,
    parameter int RD_HI_CYC     = 1,
    parameter int GAP_CYC       = 2,
    parameter int TIMEOUT_CYC   = 1024
) (
    input  logic        XCLK,
    input  logic        RST,
    input  logic        start,
    input  logic        free_run,
    output logic        CONVST_A,
    output logic        CONVST_B,
    output logic        CONVST_C,
    output logic        CONVST_D,
    output logic        CS_N,
    output logic        RD_N,
    output logic        WR_N,
    input  logic        BUSY,
    input  logic [15:0] DB,
    output logic [15:0] sample_data,
    output logic [3:0]  sample_ch,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic        frame_done,
    output logic        timeout_err,
    output logic        idle
`ifdef ADC_PAR_READ_OVERRUN_EN
    ,
    output logic [7:0]  overrun_cnt
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CONV  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RD_LO = 3'd3,
        ST_RD_HI = 3'd4,
        ST_HOLD  = 3'd5,
        ST_DRAIN = 3'd6,
        ST_GAP   = 3'd7
    } state_t;

    // Last-cycle values of the shared in-state cycle counter.
    localparam logic [15:0] CONV_LAST = 16'(CONVST_HI_CYC - 1);
    localparam logic [15:0] RDLO_LAST = 16'(RD_LO_CYC - 1);
    localparam logic [15:0] RDHI_LAST = 16'(RD_HI_CYC - 1);
    localparam logic [15:0] GAP_LAST  = 16'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYC - 1);
    localparam logic [3:0]  K_LAST    = 4'(NUM_CH - 1);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

    state_t      state_r;
    state_t      state_n;
    logic [15:0] cnt_r;
    logic [15:0] cnt_n;
    logic [3:0]  k_r;
    logic [3:0]  k_n;
    logic        arm_r;
    logic        arm_n;
    logic        capture_s;
    logic        busy_meta_r;
    logic        busy_sync_r;

    logic        conv_r;
    logic        cs_n_r;
    logic        rd_n_r;
    logic [15:0] data_r;
    logic [3:0]  ch_r;
    logic        valid_r;
    logic        done_r;
    logic        timeout_r;
    logic        idle_r;

    // Two-flop synchronizer for the asynchronous BUSY input.
    always_ff @(posedge XCLK or posedge RST) begin
        if (RST) begin
            busy_meta_r <= 1'b0;
            busy_sync_r <= 1'b0;
        end else begin
            busy_meta_r <= BUSY;
            busy_sync_r <= busy_meta_r;
        end
    end

    // Next-state, word index and BUSY arming logic.
    always_comb begin
        state_n   = state_r;
        k_n       = k_r;
        arm_n     = 1'b0;
        capture_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start || free_run) begin
                    state_n = ST_CONV;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_CONV: begin
                // A BUSY rise already visible during CONVST still arms the wait.
                arm_n = arm_r | busy_sync_r;
                if (cnt_r >= CONV_LAST) begin
                    state_n = ST_WAIT;
                end else begin
                    state_n = ST_CONV;
                end
            end
            ST_WAIT: begin
                arm_n = arm_r | busy_sync_r;
                if (arm_r && !busy_sync_r) begin
                    state_n = ST_RD_LO;
                    k_n     = 4'd0;
                end else if (cnt_r >= TMO_LAST) begin
                    state_n = ST_GAP;
                end else begin
                    state_n = ST_WAIT;
                end
            end
            ST_RD_LO: begin
                if (cnt_r >= RDLO_LAST) begin
                    capture_s = 1'b1;
                    state_n   = ST_RD_HI;
                end else begin
                    state_n = ST_RD_LO;
                end
            end
            ST_RD_HI: begin
                if (cnt_r >= RDHI_LAST) begin
                    if (k_r == K_LAST) begin
                        state_n = ST_DRAIN;
                    end else if (valid_r && !sample_ready) begin
                        state_n = ST_HOLD;
                    end else begin
                        state_n = ST_RD_LO;
                        k_n     = k_r + 4'd1;
                    end
                end else begin
                    state_n = ST_RD_HI;
                end
            end
            ST_HOLD: begin
                if (!valid_r || sample_ready) begin
                    state_n = ST_RD_LO;
                    k_n     = k_r + 4'd1;
                end else begin
                    state_n = ST_HOLD;
                end
            end
            ST_DRAIN: begin
                if (!valid_r || sample_ready) begin
                    state_n = ST_GAP;
                end else begin
                    state_n = ST_DRAIN;
                end
            end
            ST_GAP: begin
                if (cnt_r >= GAP_LAST) begin
                    if (free_run) begin
                        state_n = ST_CONV;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    state_n = ST_GAP;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // In-state cycle counter; DRAIN time counts toward the CS_N-high gap so
    // CONVST follows CS_N rising by GAP_CYC cycles when the stream keeps up.
    always_comb begin
        cnt_n = 16'd0;
        if ((state_n == state_r) || ((state_r == ST_DRAIN) && (state_n == ST_GAP))) begin
            cnt_n = sat_inc(cnt_r);
        end else begin
            cnt_n = 16'd0;
        end
    end

    // FSM state, counter and registered bus strobes.
    always_ff @(posedge XCLK or posedge RST) begin
        if (RST) begin
            state_r <= ST_IDLE;
            cnt_r   <= 16'd0;
            k_r     <= 4'd0;
            arm_r   <= 1'b0;
            conv_r  <= 1'b0;
            cs_n_r  <= 1'b1;
            rd_n_r  <= 1'b1;
            idle_r  <= 1'b1;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            k_r     <= k_n;
            arm_r   <= arm_n;
            conv_r  <= (state_n == ST_CONV);
            cs_n_r  <= !((state_n == ST_RD_LO) || (state_n == ST_RD_HI) || (state_n == ST_HOLD));
            rd_n_r  <= (state_n != ST_RD_LO);
            idle_r  <= (state_n == ST_IDLE);
        end
    end

    // Sample stream register, frame_done pulse and sticky timeout flag.
    always_ff @(posedge XCLK or posedge RST) begin
        if (RST) begin
            data_r    <= 16'd0;
            ch_r      <= 4'd0;
            valid_r   <= 1'b0;
            done_r    <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            if (capture_s) begin
                data_r  <= DB;
                ch_r    <= k_r;
                valid_r <= 1'b1;
            end else if (sample_ready) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
            done_r <= (state_r == ST_DRAIN) && (state_n == ST_GAP);
            if ((state_r == ST_WAIT) && (state_n == ST_GAP)) begin
                timeout_r <= 1'b1;
            end else begin
                timeout_r <= timeout_r;
            end
        end
    end

`ifdef ADC_PAR_READ_OVERRUN_EN
    logic [7:0] overrun_r;

    // Saturating count of start requests that arrive while a frame is active.
    always_ff @(posedge XCLK or posedge RST) begin
        if (RST) begin
            overrun_r <= 8'd0;
        end else if (start && (state_r != ST_IDLE) && (overrun_r != 8'hFF)) begin
            overrun_r <= overrun_r + 8'd1;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign overrun_cnt = overrun_r;
`endif

    assign CONVST_A     = conv_r;
    assign CONVST_B     = conv_r;
    assign CONVST_C     = conv_r;
    assign CONVST_D     = conv_r;
    assign CS_N         = cs_n_r;
    assign RD_N         = rd_n_r;
    assign WR_N         = 1'b1;
    assign sample_data  = data_r;
    assign sample_ch    = ch_r;
    assign sample_valid = valid_r;
    assign frame_done   = done_r;
    assign timeout_err  = timeout_r;
    assign idle         = idle_r;

endmodule

// File: tb/tb_adc_par_read_ctrl.sv
// ---------------------------------------------------------------------------
// tb_adc_par_read_ctrl
//
// Self-checking bench for adc_par_read_ctrl. A small ADC model answers
// CONVST with a BUSY pulse and drives DB = base + (RD_N pulse index).
// A table of frame vectors covers normal reads and backpressure; hand-written
// sequences cover BUSY timeout, free-running frames, mid-frame reset and
// (with ADC_PAR_READ_OVERRUN_EN) the overrun counter.
// ---------------------------------------------------------------------------
module tb_adc_par_read_ctrl;

    localparam int NUM_CH = 8;

    logic        XCLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic        free_run = 1'b0;
    logic        BUSY = 1'b0;
    logic        sample_ready = 1'b1;
    logic [15:0] DB;
    logic        CONVST_A, CONVST_B, CONVST_C, CONVST_D;
    logic        CS_N, RD_N, WR_N;
    logic [15:0] sample_data;
    logic [3:0]  sample_ch;
    logic        sample_valid, frame_done, timeout_err, idle;
`ifdef ADC_PAR_READ_OVERRUN_EN
    logic [7:0]  overrun_cnt;
`endif

    adc_par_read_ctrl dut (
        .XCLK(XCLK), .RST(RST), .start(start), .free_run(free_run),
        .CONVST_A(CONVST_A), .CONVST_B(CONVST_B), .CONVST_C(CONVST_C), .CONVST_D(CONVST_D),
        .CS_N(CS_N), .RD_N(RD_N), .WR_N(WR_N), .BUSY(BUSY), .DB(DB),
        .sample_data(sample_data), .sample_ch(sample_ch), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .frame_done(frame_done), .timeout_err(timeout_err),
        .idle(idle)
`ifdef ADC_PAR_READ_OVERRUN_EN
        , .overrun_cnt(overrun_cnt)
`endif
    );

    always #5 XCLK = ~XCLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- ADC model ----------------
    logic [15:0] db_base = 16'h1000;
    int          busy_len = 40;
    bit          busy_stuck = 1'b0;
    int          rd_idx = 0;

    assign DB = db_base + 16'(rd_idx);

    initial forever begin
        @(posedge CONVST_A or posedge RD_N);
        if (CONVST_A) rd_idx = 0;
        else          rd_idx = rd_idx + 1;
    end

    initial forever begin
        @(posedge CONVST_A);
        @(negedge XCLK);
        BUSY = 1'b1;
        if (busy_stuck) wait (!busy_stuck);
        else repeat (busy_len) @(negedge XCLK);
        BUSY = 1'b0;
    end

    // ---------------- Monitor ----------------
    int          cyc = 0;
    int          rd_pulses, cs_windows, done_cnt, rd_bad, conv_bad;
    int          cs_rise_cyc, idle_rise_cyc, conv_fall_cyc;
    bit          cs_pend;
    int          gap_q[$];
    logic [15:0] beat_data[$];
    logic [3:0]  beat_ch[$];
    logic        p_rd_n = 1'b1, p_cs_n = 1'b1, p_conv = 1'b0, p_idle = 1'b1;
    logic        p_valid = 1'b0, p_ready = 1'b0;
    logic [15:0] p_data = 16'd0;
    logic [3:0]  p_ch = 4'd0;

    initial begin
        conv_bad = 0;
        forever begin
            @(negedge XCLK);
            #1;
            cyc++;
            if (!RST) begin
                if (p_valid && !p_ready) begin
                    check("hold_valid", 32'(sample_valid), 32'd1);
                    check("hold_data", 32'(sample_data), 32'(p_data));
                    check("hold_ch", 32'(sample_ch), 32'(p_ch));
                end
                if (sample_valid && sample_ready) begin
                    beat_data.push_back(sample_data);
                    beat_ch.push_back(sample_ch);
                end
                if (p_rd_n && !RD_N) rd_pulses++;
                if (!RD_N && CS_N) rd_bad++;
                if (p_cs_n && !CS_N) cs_windows++;
                if (!p_cs_n && CS_N) begin
                    cs_rise_cyc = cyc;
                    cs_pend = 1'b1;
                end
                if (!p_conv && CONVST_A) begin
                    if (cs_pend) gap_q.push_back(cyc - cs_rise_cyc);
                    cs_pend = 1'b0;
                end
                if (p_conv && !CONVST_A) conv_fall_cyc = cyc;
                if (!p_idle && idle) idle_rise_cyc = cyc;
                if (frame_done) done_cnt++;
                if ((CONVST_A != CONVST_B) || (CONVST_A != CONVST_C) || (CONVST_A != CONVST_D)) conv_bad++;
            end
            p_rd_n = RD_N; p_cs_n = CS_N; p_conv = CONVST_A; p_idle = idle;
            p_valid = sample_valid; p_ready = sample_ready;
            p_data = sample_data; p_ch = sample_ch;
        end
    end

    task automatic clear_mon();
        beat_data.delete(); beat_ch.delete(); gap_q.delete();
        rd_pulses = 0; cs_windows = 0; done_cnt = 0; rd_bad = 0; cs_pend = 1'b0;
        cs_rise_cyc = 0; idle_rise_cyc = 0; conv_fall_cyc = 0;
    endtask

    // ---------------- Helpers ----------------
    task automatic do_start();
        @(negedge XCLK); start = 1'b1;
        @(negedge XCLK); start = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        do begin @(negedge XCLK); n++; end while (!idle && n < limit);
        check("idle_reached", 32'(idle), 32'd1);
        #2;
    endtask

    task automatic wait_ch(input logic [3:0] ch);
        int n = 0;
        do begin @(negedge XCLK); n++; end while (!(sample_valid && sample_ch == ch) && n < 500);
        check("wait_word", 32'(sample_valid && sample_ch == ch), 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_convst"},   32'({CONVST_A, CONVST_B, CONVST_C, CONVST_D}), 32'd0);
        check({tag, "_cs_n"},     32'(CS_N), 32'd1);
        check({tag, "_rd_n"},     32'(RD_N), 32'd1);
        check({tag, "_wr_n"},     32'(WR_N), 32'd1);
        check({tag, "_valid"},    32'(sample_valid), 32'd0);
        check({tag, "_data"},     32'(sample_data), 32'd0);
        check({tag, "_ch"},       32'(sample_ch), 32'd0);
        check({tag, "_done"},     32'(frame_done), 32'd0);
        check({tag, "_timeout"},  32'(timeout_err), 32'd0);
        check({tag, "_idle"},     32'(idle), 32'd1);
    endtask

    // ---------------- Vector table ----------------
    typedef struct {
        logic [15:0] base;
        int          busy;
        bit          stall_en;
        logic [3:0]  stall_ch;
        int          stall_len;
        int          exp_beats;
        int          exp_rd;
        int          exp_done;
        int          exp_idle_gap;   // cycles from CS_N rising to idle rising
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input int idx);
        vec_t v;
        v = vecs[idx];
        clear_mon();
        db_base = v.base;
        busy_len = v.busy;
        do_start();
        if (v.stall_en) begin
            wait_ch(v.stall_ch);
            sample_ready = 1'b0;
            for (int c = 0; c < v.stall_len; c++) begin
                @(negedge XCLK);
                check($sformatf("v%0d_stall_valid", idx), 32'(sample_valid), 32'd1);
                check($sformatf("v%0d_stall_data", idx), 32'(sample_data), 32'(v.base + 16'(v.stall_ch)));
                check($sformatf("v%0d_stall_rd_n", idx), 32'(RD_N), 32'd1);
                if (v.stall_ch != 4'(NUM_CH - 1))
                    check($sformatf("v%0d_stall_cs_n", idx), 32'(CS_N), 32'd0);
                else
                    check($sformatf("v%0d_drain_cs_n", idx), 32'(CS_N), 32'd1);
            end
            sample_ready = 1'b1;
        end
        wait_idle(2000);
        check($sformatf("v%0d_beats", idx), 32'(beat_data.size()), 32'(v.exp_beats));
        for (int i = 0; i < beat_data.size() && i < NUM_CH; i++) begin
            check($sformatf("v%0d_beat%0d_data", idx, i), 32'(beat_data[i]), 32'(v.base + 16'(i)));
            check($sformatf("v%0d_beat%0d_ch", idx, i), 32'(beat_ch[i]), 32'(i));
        end
        check($sformatf("v%0d_rd_pulses", idx), 32'(rd_pulses), 32'(v.exp_rd));
        check($sformatf("v%0d_cs_windows", idx), 32'(cs_windows), 32'd1);
        check($sformatf("v%0d_frame_done", idx), 32'(done_cnt), 32'(v.exp_done));
        check($sformatf("v%0d_cs_to_idle", idx), 32'(idle_rise_cyc - cs_rise_cyc), 32'(v.exp_idle_gap));
        check($sformatf("v%0d_rd_outside_cs", idx), 32'(rd_bad), 32'd0);
        check($sformatf("v%0d_timeout", idx), 32'(timeout_err), 32'd0);
    endtask

    // ---------------- Main sequence ----------------
    initial begin
        int fr;
        int n;

        vecs[0] = '{16'h1000, 40, 1'b0, 4'd0, 0,  8, 8, 1, 2};
        vecs[1] = '{16'h1000, 40, 1'b1, 4'd3, 10, 8, 8, 1, 2};
        vecs[2] = '{16'h2A50, 5,  1'b1, 4'd0, 3,  8, 8, 1, 2};
        vecs[3] = '{16'hFFF8, 12, 1'b1, 4'd7, 4,  8, 8, 1, 5};
        vecs[4] = '{16'h0000, 3,  1'b0, 4'd0, 0,  8, 8, 1, 2};
        clear_mon();

        repeat (3) @(negedge XCLK);
        check_reset_vals("reset");
        RST = 1'b0;
        repeat (2) @(negedge XCLK);
        check_reset_vals("post_reset");
`ifdef ADC_PAR_READ_OVERRUN_EN
        check("ovr_reset", 32'(overrun_cnt), 32'd0);
`endif

        for (int i = 0; i < 5; i++) run_vec(i);

        // BUSY stuck high: timeout after TIMEOUT_CYC cycles in WAIT_BUSY.
        clear_mon();
        busy_stuck = 1'b1;
        do_start();
        wait_idle(1200);
        check("tmo_flag", 32'(timeout_err), 32'd1);
        check("tmo_frame_done", 32'(done_cnt), 32'd0);
        check("tmo_cs_windows", 32'(cs_windows), 32'd0);
        check("tmo_beats", 32'(beat_data.size()), 32'd0);
        check("tmo_wait_plus_gap", 32'(idle_rise_cyc - conv_fall_cyc), 32'd1026);
        busy_stuck = 1'b0;
        repeat (5) @(negedge XCLK);

        // Free-running: three back-to-back frames.
        clear_mon();
        db_base = 16'h3300;
        busy_len = 20;
        @(negedge XCLK);
        free_run = 1'b1;
        fr = 0;
        n = 0;
        while (fr < 3 && n < 1000) begin
            @(negedge XCLK);
            n++;
            if (frame_done) fr++;
        end
        free_run = 1'b0;
        check("fr_frames", 32'(fr), 32'd3);
        wait_idle(300);
        check("fr_beats", 32'(beat_data.size()), 32'd24);
        for (int i = 0; i < beat_data.size() && i < 24; i++) begin
            check($sformatf("fr_beat%0d_data", i), 32'(beat_data[i]), 32'(16'h3300 + 16'(i % NUM_CH)));
            check($sformatf("fr_beat%0d_ch", i), 32'(beat_ch[i]), 32'(i % NUM_CH));
        end
        check("fr_cs_windows", 32'(cs_windows), 32'd3);
        check("fr_rd_pulses", 32'(rd_pulses), 32'd24);
        check("fr_frame_done", 32'(done_cnt), 32'd3);
        check("fr_gap_count", 32'(gap_q.size()), 32'd2);
        for (int i = 0; i < gap_q.size(); i++)
            check($sformatf("fr_gap%0d", i), 32'(gap_q[i]), 32'd2);
        check("fr_timeout_sticky", 32'(timeout_err), 32'd1);

        // Reset in the middle of word 4.
        clear_mon();
        db_base = 16'h5000;
        busy_len = 10;
        do_start();
        wait_ch(4'd4);
        #2;
        RST = 1'b1;
        #1;
        check_reset_vals("async_reset");
        repeat (2) @(negedge XCLK);
        RST = 1'b0;
        clear_mon();
        repeat (60) @(negedge XCLK);
        #2;
        check("rst_no_beats", 32'(beat_data.size()), 32'd0);
        check("rst_no_rd", 32'(rd_pulses), 32'd0);
        check("rst_no_cs", 32'(cs_windows), 32'd0);
        check("rst_no_done", 32'(done_cnt), 32'd0);
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_valid", 32'(sample_valid), 32'd0);

`ifdef ADC_PAR_READ_OVERRUN_EN
        // Start pulses during free-running frames are dropped and counted.
        check("ovr_zero", 32'(overrun_cnt), 32'd0);
        free_run = 1'b1;
        repeat (3) @(negedge XCLK);
        for (int i = 0; i < 300; i++) begin
            start = 1'b1;
            @(negedge XCLK);
            start = 1'b0;
            @(negedge XCLK);
            if (i == 99) check("ovr_100", 32'(overrun_cnt), 32'd100);
        end
        check("ovr_sat", 32'(overrun_cnt), 32'd255);
        free_run = 1'b0;
        wait_idle(300);
`endif

        check("convst_identical", 32'(conv_bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
